fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and PC-sequencing stage that sits directly upstream of the main controller.
- Holds the PC and drives instruction memory through a ready handshake.
- Latches the fetched word and presents opcode/func to the controller.
- Computes the next PC from the controller's Jump/Branch codes, the ALU zero flag and the register-file rs value.
- Each instruction takes one EXEC cycle; fetch wait states are absorbed here.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC and instruction-memory address width (bits [1:0] always 0)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request, registered
imem_addr  output  ADDR_W  fetch address, equals pc
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  instruction-memory ready; sampled only in FETCH
Jump  input  2  from controller: 00 seq, 01 jr, 11 j/jal, 10 reserved
Branch  input  2  from controller: 00 none, 01 beq, 11 bne, 10 reserved
zero  input  1  ALU zero flag of the current instruction
jr_target  input  32  rs value for jr
stall  input  1  hold current instruction in EXEC
instr  output  32  latched instruction word
opcode  output  6  instr[31:26]
func  output  6  instr[5:0]
pc  output  ADDR_W  address of the current instruction
pc_plus4  output  ADDR_W  pc+4, the jal link value
instr_valid  output  1  high in EXEC; downstream writes are gated by it
misalign  output  1  one-cycle pulse: jr target had [1:0]!=0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, instr=0, imem_req=0, instr_valid=0, misalign=0.
  - All state is cleared immediately, including mid-fetch or mid-EXEC; any outstanding fetch is abandoned.
- IDLE: lasts exactly one cycle after reset release, then moves to FETCH with imem_req=1.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - While imem_ready=0, the state is held and pc is stable.
  - On imem_ready=1: instr<=imem_rdata, imem_req<=0, state moves to EXEC.
  - Minimum fetch latency is 1 cycle, so instr_valid rises the cycle after ready.
- EXEC:
  - instr_valid=1 and the controller decodes opcode/func combinationally.
  - If stall=1: hold EXEC; pc and instr are unchanged; no misalign pulse.
  - Else: pc<=next_pc, state moves to FETCH, imem_req<=1.
- imem_ready is ignored outside FETCH.
- next_pc (all 32-bit, wrapping modulo 2^32, no overflow flag):
  - seq = pc+4.
  - branch target = pc+4 + (sign_extend(instr[15:0])<<2).
  - jump target = {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Priority:
    1. Jump==11 -> jump target.
    2. Jump==01 -> {jr_target[31:2], 2'b00}.
    3. Branch==01 & zero -> branch target.
    4. Branch==11 & !zero -> branch target.
    5. Otherwise seq. Reserved codes (Jump 10, Branch 10) give seq.
- misalign:
  - Pulses for exactly the cycle after a non-stalled EXEC with Jump==01 and jr_target[1:0]!=0.
  - The low bits are still forced to 00; there is no trap.
- opcode and func are direct slices of instr; they are 0 during reset and IDLE.
- pc_plus4 is combinational from pc.
- Stall during FETCH has no effect; stall is sampled only in EXEC.
- pc wrap: pc=32'hFFFF_FFFC with seq gives 0.

Test Plan:
- Reset/sequential:
  - Stimulus: rst_n low then released; imem_ready tied 1; memory word at 0 = 32'h2008_0005 (addi).
  - Required: first imem_req 1 cycle after release; instr_valid on the 3rd cycle; opcode=6'b001000; next fetch address 4.
- Wait states:
  - Stimulus: imem_ready low for 2 cycles in FETCH.
  - Required: imem_addr stable for 3 cycles; instr latched only on the ready cycle; exactly one EXEC cycle.
- Branch:
  - beq at pc=0x10, imm=16'hFFFF, zero=1 -> next pc=0x10.
  - Same with zero=0 -> 0x14.
  - bne imm=16'h0003, zero=0 -> 0x20.
- Jump/jal:
  - pc=0x4000_0000, instr=32'h0C00_0010 (jal), Jump=11.
  - Required: next pc=0x4000_0040; pc_plus4=0x4000_0004 during EXEC.
- jr misaligned:
  - Jump=01, jr_target=0x0000_0103.
  - Required: next pc=0x100; misalign high for exactly 1 cycle.
  - Same case with stall=1 for 2 cycles: no pulse, pc held, then the transition on release.
- Reset mid-operation:
  - Stimulus: assert rst_n low in FETCH with imem_ready pending, and separately in EXEC.
  - Required: immediate pc=RESET_PC, instr_valid=0, imem_req=0; restart via IDLE.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch and PC-sequencing stage: fetches through a ready handshake,
// holds the current instruction for one EXEC cycle and computes the next PC.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    input  logic [1:0]        Jump,
    input  logic [1:0]        Branch,
    input  logic              zero,
    input  logic [31:0]       jr_target,
    input  logic              stall,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [5:0]        func,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              instr_valid,
    output logic              misalign
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              req_q, req_d;
    logic              valid_q, valid_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] pc_plus4_s;
    logic [ADDR_W-1:0] branch_tgt_s;
    logic [ADDR_W-1:0] jump_tgt_s;
    logic [ADDR_W-1:0] next_pc_s;

    // State and registered outputs; reset abandons any fetch in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0000_0000;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state: one IDLE cycle, FETCH until ready, EXEC until stall drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready) state_d = S_EXEC;
                else            state_d = S_FETCH;
            end
            S_EXEC: begin
                if (stall) state_d = S_EXEC;
                else       state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next-PC selection; jr low bits are forced to zero, misalignment only flagged.
    always_comb begin
        pc_plus4_s   = pc_q + 32'd4;
        branch_tgt_s = pc_plus4_s + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        jump_tgt_s   = {pc_plus4_s[ADDR_W-1:ADDR_W-4], instr_q[25:0], 2'b00};
        if (Jump == 2'b11) begin
            next_pc_s = jump_tgt_s;
        end else if (Jump == 2'b01) begin
            next_pc_s = {jr_target[31:2], 2'b00};
        end else if ((Branch == 2'b01) && zero) begin
            next_pc_s = branch_tgt_s;
        end else if ((Branch == 2'b11) && !zero) begin
            next_pc_s = branch_tgt_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Output / datapath next values, derived from the current and next state.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = 1'b0;
        if ((state_q == S_FETCH) && imem_ready) begin
            instr_d = imem_rdata;
        end else if ((state_q == S_EXEC) && !stall) begin
            pc_d       = next_pc_s;
            misalign_d = (Jump == 2'b01) && (jr_target[1:0] != 2'b00);
        end else begin
            pc_d = pc_q;
        end
        req_d   = (state_d == S_FETCH);
        valid_d = (state_d == S_EXEC);
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_s;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign func        = instr_q[5:0];
    assign instr_valid = valid_q;
    assign misalign    = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: controller and memory are
// driven directly by the bench, with hand-computed PC sequences.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [1:0]  Jump;
    logic [1:0]  Branch;
    logic        zero;
    logic [31:0] jr_target;
    logic        stall;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .Jump(Jump), .Branch(Branch), .zero(zero),
        .jr_target(jr_target), .stall(stall),
        .instr(instr), .opcode(opcode), .func(func),
        .pc(pc), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid), .misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word with ready high for one FETCH cycle; returns in EXEC.
    task automatic fetch_exec(input logic [31:0] word);
        imem_rdata = word;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
    endtask

    task automatic ctrl(input logic [1:0] j, input logic [1:0] b, input logic z, input logic s);
        Jump   = j;
        Branch = b;
        zero   = z;
        stall  = s;
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_rdata = 32'h2008_0005;
        imem_ready = 1'b1;
        jr_target  = 32'h0000_0000;
        ctrl(2'b00, 2'b00, 1'b0, 1'b0);

        // Reset state and sequential start-up
        step(); step(); step();
        chk("rst_pc",       pc,                   32'h0000_0000);
        chk("rst_instr",    instr,                32'h0000_0000);
        chk("rst_req",      32'(imem_req),        32'd0);
        chk("rst_valid",    32'(instr_valid),     32'd0);
        chk("rst_misalign", 32'(misalign),        32'd0);
        chk("rst_opcode",   32'(opcode),          32'd0);
        rst_n = 1'b1;
        #2;
        chk("idle_req",     32'(imem_req),        32'd0);
        step();
        chk("first_req",    32'(imem_req),        32'd1);
        chk("first_addr",   imem_addr,            32'h0000_0000);
        chk("first_valid",  32'(instr_valid),     32'd0);
        step();
        chk("seq_valid",    32'(instr_valid),     32'd1);
        chk("seq_opcode",   32'(opcode),          32'h0000_0008);
        chk("seq_instr",    instr,                32'h2008_0005);
        chk("seq_req_low",  32'(imem_req),        32'd0);
        step();
        chk("seq_next_addr", imem_addr,           32'h0000_0004);
        chk("seq_next_req", 32'(imem_req),        32'd1);
        chk("seq_exec_once", 32'(instr_valid),    32'd0);

        // Wait states: two cycles of ready low, garbage data not latched
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("ws_addr1",     imem_addr,            32'h0000_0004);
        chk("ws_instr1",    instr,                32'h2008_0005);
        chk("ws_valid1",    32'(instr_valid),     32'd0);
        step();
        chk("ws_addr2",     imem_addr,            32'h0000_0004);
        chk("ws_instr2",    instr,                32'h2008_0005);
        fetch_exec(32'h0800_0004);
        chk("ws_valid",     32'(instr_valid),     32'd1);
        chk("ws_instr",     instr,                32'h0800_0004);
        ctrl(2'b11, 2'b00, 1'b0, 1'b0);
        step();
        ctrl(2'b00, 2'b00, 1'b0, 1'b0);
        chk("ws_one_exec",  32'(instr_valid),     32'd0);
        chk("j_to_10",      pc,                   32'h0000_0010);

        // Branches
        fetch_exec(32'h1000_FFFF);
        ctrl(2'b00, 2'b01, 1'b1, 1'b0);
        step();
        chk("beq_taken",    pc,                   32'h0000_0010);
        fetch_exec(32'h1400_0003);
        ctrl(2'b00, 2'b11, 1'b0, 1'b0);
        step();
        chk("bne_taken",    pc,                   32'h0000_0020);
        fetch_exec(32'h0800_0004);
        ctrl(2'b11, 2'b00, 1'b0, 1'b0);
        step();
        chk("j_back_10",    pc,                   32'h0000_0010);
        fetch_exec(32'h1000_FFFF);
        ctrl(2'b00, 2'b01, 1'b0, 1'b0);
        step();
        chk("beq_not_taken", pc,                  32'h0000_0014);

        // jr to 0x4000_0000, then jal
        fetch_exec(32'h0000_0000);
        ctrl(2'b01, 2'b00, 1'b0, 1'b0);
        jr_target = 32'h4000_0000;
        step();
        chk("jr_aligned",   pc,                   32'h4000_0000);
        chk("jr_no_mis",    32'(misalign),        32'd0);
        ctrl(2'b00, 2'b00, 1'b0, 1'b0);
        fetch_exec(32'h0C00_0010);
        chk("jal_pc4",      pc_plus4,             32'h4000_0004);
        chk("jal_opcode",   32'(opcode),          32'h0000_0003);
        chk("jal_func",     32'(func),            32'h0000_0010);
        ctrl(2'b11, 2'b00, 1'b0, 1'b0);
        step();
        chk("jal_target",   pc,                   32'h4000_0040);

        // Misaligned jr
        fetch_exec(32'h0000_0000);
        ctrl(2'b01, 2'b00, 1'b0, 1'b0);
        jr_target = 32'h0000_0103;
        step();
        ctrl(2'b00, 2'b00, 1'b0, 1'b0);
        chk("jr_mis_pc",    pc,                   32'h0000_0100);
        chk("jr_mis_pulse", 32'(misalign),        32'd1);
        step();
        chk("jr_mis_once",  32'(misalign),        32'd0);

        // Misaligned jr under stall
        fetch_exec(32'h0000_0000);
        ctrl(2'b01, 2'b00, 1'b0, 1'b1);
        jr_target = 32'h0000_0207;
        step();
        chk("stall1_valid", 32'(instr_valid),     32'd1);
        chk("stall1_pc",    pc,                   32'h0000_0100);
        chk("stall1_mis",   32'(misalign),        32'd0);
        step();
        chk("stall2_valid", 32'(instr_valid),     32'd1);
        chk("stall2_pc",    pc,                   32'h0000_0100);
        chk("stall2_mis",   32'(misalign),        32'd0);
        stall = 1'b0;
        step();
        ctrl(2'b00, 2'b00, 1'b0, 1'b0);
        chk("unstall_pc",   pc,                   32'h0000_0204);
        chk("unstall_valid", 32'(instr_valid),    32'd0);
        chk("unstall_mis",  32'(misalign),        32'd1);
        step();
        chk("unstall_mis_once", 32'(misalign),    32'd0);

        // Reset while FETCH is pending
        #2 rst_n = 1'b0;
        #1;
        chk("rstf_pc",      pc,                   32'h0000_0000);
        chk("rstf_req",     32'(imem_req),        32'd0);
        chk("rstf_valid",   32'(instr_valid),     32'd0);
        #2 rst_n = 1'b1;
        step();
        chk("rstf_restart_req", 32'(imem_req),    32'd1);
        chk("rstf_restart_addr", imem_addr,       32'h0000_0000);

        // PC wrap through reserved control codes
        fetch_exec(32'h0000_0000);
        ctrl(2'b01, 2'b00, 1'b0, 1'b0);
        jr_target = 32'hFFFF_FFFC;
        step();
        chk("wrap_setup",   pc,                   32'hFFFF_FFFC);
        fetch_exec(32'h0000_0000);
        chk("wrap_pc4",     pc_plus4,             32'h0000_0000);
        ctrl(2'b10, 2'b10, 1'b1, 1'b0);
        step();
        chk("wrap_reserved_seq", pc,              32'h0000_0000);

        // Reset during EXEC
        fetch_exec(32'h0000_0000);
        ctrl(2'b01, 2'b00, 1'b0, 1'b0);
        jr_target = 32'h0000_0080;
        step();
        chk("rste_setup",   pc,                   32'h0000_0080);
        fetch_exec(32'h2008_0005);
        ctrl(2'b00, 2'b00, 1'b0, 1'b1);
        step();
        chk("rste_in_exec", 32'(instr_valid),     32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rste_pc",      pc,                   32'h0000_0000);
        chk("rste_valid",   32'(instr_valid),     32'd0);
        chk("rste_instr",   instr,                32'h0000_0000);
        chk("rste_opcode",  32'(opcode),          32'd0);
        chk("rste_req",     32'(imem_req),        32'd0);
        stall = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        chk("rste_idle_req", 32'(imem_req),       32'd0);
        step();
        chk("rste_restart_req", 32'(imem_req),    32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
